// File: rtl/cmp_minmax_pkg.sv
// Shared definitions for the running min/max sequencer.
//   DATA_W          : sample width (4-bit unsigned nibbles)
//   LEN_MAX_DEFAULT : default maximum burst length
//   state_t         : sequencer states
package cmp_minmax_pkg;

    localparam int DATA_W          = 4;
    localparam int LEN_MAX_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/cmp_unit_4b.sv
// Combinational unsigned magnitude comparator.
// Ports:
//   a, b : operands (DATA_W bits, unsigned)
//   eq   : a == b
//   gt   : a >  b
//   lt   : a <  b
module cmp_unit_4b
    import cmp_minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              eq,
    output logic              gt,
    output logic              lt
);

    assign eq = (a == b);
    assign gt = (a >  b);
    assign lt = (a <  b);

endmodule

// File: rtl/cmp_minmax_seq.sv
// Running maximum/minimum (value and first index) over a burst of 4-bit
// samples. One comparator is time-shared between the max job (CMP_MAX) and
// the min job (CMP_MIN).
//
// Handshake: a sample transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in FETCH.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, len         : burst request, sampled only in IDLE
//   in_valid, in_data  : sample stream input
//   in_ready           : sample can be accepted this cycle
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse, results valid
//   err                : one-cycle pulse, start rejected (bad len)
//   max_val, max_idx   : largest sample and its first index
//   min_val, min_idx   : smallest sample and its first index
//
// Build option: define CMP_SKIP_MIN_EN to skip CMP_MIN for a sample that
// just raised the maximum (a new maximum can never be a new minimum once the
// first sample has seeded both).
module cmp_minmax_seq
    import cmp_minmax_pkg::*;
#(
    parameter int LEN_MAX = LEN_MAX_DEFAULT,
    parameter int LEN_W   = 5,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] min_val,
    output logic [IDX_W-1:0]  min_idx
);

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   cnt;
    logic [DATA_W-1:0]  sreg;

    logic [DATA_W-1:0]  cmp_b;
    logic               cmp_eq;
    logic               cmp_gt;
    logic               cmp_lt;

    logic               len_ok;
    logic               first_smp;
    logic               last_smp;
    logic               len_one;
    logic               upd_max;
    logic               upd_min;

    assign len_ok    = (len != '0) && (len <= LEN_W'(LEN_MAX));
    assign first_smp = (cnt == '0);
    assign last_smp  = (LEN_W'(cnt) == (len_q - LEN_W'(1)));
    assign len_one   = (len_q == LEN_W'(1));

    // Equal values never update, so the earliest index of a tie is kept.
    assign upd_max = (state == CMP_MAX) && cmp_gt && !cmp_eq;
    assign upd_min = (state == CMP_MIN) && cmp_lt && !cmp_eq;

    // Comparator operand b follows the active job; a is always the sample.
    always_comb begin
        cmp_b = '0;
        case (state)
            CMP_MAX: cmp_b = max_val;
            CMP_MIN: cmp_b = min_val;
            default: cmp_b = '0;
        endcase
    end

    cmp_unit_4b u_cmp (
        .a  (sreg),
        .b  (cmp_b),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && len_ok) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (first_smp) begin
                        state_next = len_one ? DONE : FETCH;
                    end else begin
                        state_next = CMP_MAX;
                    end
                end
            end
            CMP_MAX: begin
`ifdef CMP_SKIP_MIN_EN
                if (upd_max) begin
                    state_next = last_smp ? DONE : FETCH;
                end else begin
                    state_next = CMP_MIN;
                end
`else
                state_next = CMP_MIN;
`endif
            end
            CMP_MIN: begin
                state_next = last_smp ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: length, counter, sample and result registers, err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            cnt     <= '0;
            sreg    <= '0;
            max_val <= '0;
            max_idx <= '0;
            min_val <= '0;
            min_idx <= '0;
            err     <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && !len_ok;
            case (state)
                IDLE: begin
                    if (start && len_ok) begin
                        len_q <= len;
                        cnt   <= '0;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        sreg <= in_data;
                        // The first sample seeds both results directly.
                        if (first_smp) begin
                            max_val <= in_data;
                            min_val <= in_data;
                            max_idx <= '0;
                            min_idx <= '0;
                            if (!len_one) begin
                                cnt <= cnt + IDX_W'(1);
                            end
                        end
                    end
                end
                CMP_MAX: begin
                    if (upd_max) begin
                        max_val <= sreg;
                        max_idx <= cnt;
`ifdef CMP_SKIP_MIN_EN
                        if (!last_smp) begin
                            cnt <= cnt + IDX_W'(1);
                        end
`endif
                    end
                end
                CMP_MIN: begin
                    if (upd_min) begin
                        min_val <= sreg;
                        min_idx <= cnt;
                    end
                    if (!last_smp) begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_minmax_seq.sv
module tb_cmp_minmax_seq;

    localparam int LEN_MAX = 16;
    localparam int LEN_W   = 5;
    localparam int IDX_W   = 4;
`ifdef CMP_SKIP_MIN_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    typedef logic [3:0] smp_arr_t [16];

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       max_val;
    logic [IDX_W-1:0] max_idx;
    logic [3:0]       min_val;
    logic [IDX_W-1:0] min_idx;

    cmp_minmax_seq #(.LEN_MAX(LEN_MAX), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .max_val  (max_val),
        .max_idx  (max_idx),
        .min_val  (min_val),
        .min_idx  (min_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    int          lat_q[$];
    int          start_cyc = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          ready_cnt = 0;
    logic [15:0] last_res  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain scan for first max / first min; latency from cycle rules.
    function automatic void model(input int n, input smp_arr_t d,
                                  output logic [15:0] res, output int lat);
        logic [3:0] mx, mi;
        int xi, ni, nskip;
        mx = d[0]; mi = d[0]; xi = 0; ni = 0; nskip = 0;
        for (int i = 1; i < n; i++) begin
            if (d[i] > mx) begin mx = d[i]; xi = i; nskip++; end
            if (d[i] < mi) begin mi = d[i]; ni = i; end
        end
        res = {mx, 4'(xi), mi, 4'(ni)};
        lat = 3 * n - 1 - SKIP * nskip;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [15:0] e;
        int          l;
        if (!rst) begin
            if (in_ready) ready_cnt++;
            if (err) err_cnt++;
            check("ready_implies_busy", {31'b0, in_ready & ~busy}, 0);
            check("done_err_exclusive", {31'b0, done & err}, 0);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("max_val", {28'b0, max_val}, {28'b0, e[15:12]});
                    check("max_idx", {28'b0, max_idx}, {28'b0, e[11:8]});
                    check("min_val", {28'b0, min_val}, {28'b0, e[7:4]});
                    check("min_idx", {28'b0, min_idx}, {28'b0, e[3:0]});
                    if (l >= 0) check("done_latency", cyc - start_cyc, l);
                    last_res = e;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 0);
        check({tag, "_busy"},     {31'b0, busy}, 0);
        check({tag, "_done"},     {31'b0, done}, 0);
        check({tag, "_err"},      {31'b0, err}, 0);
        check({tag, "_results"},  {16'b0, max_val, max_idx, min_val, min_idx}, 0);
    endtask

    task automatic run_burst(input int n, input smp_arr_t d, input int gap,
                             input logic [15:0] exp_res, input int exp_lat,
                             input bit poke_start);
        int d0, e0, b;
        bit rdy;
        exp_q.push_back(exp_res);
        lat_q.push_back(gap == 0 ? exp_lat : -1);
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk); #1;
        start = 1'b1; len = LEN_W'(n); start_cyc = cyc; ready_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0; len = LEN_W'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; in_data = 4'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = d[i];
            if (poke_start && i == 2) begin start = 1'b1; len = LEN_W'(n); end
            rdy = 1'b0; b = 0;
            while (!rdy && b < 100) begin
                @(negedge clk); rdy = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                b++;
            end
            if (!rdy) check("fetch_timeout", 0, 1);
        end
        in_valid = 1'b0; in_data = 4'($urandom);
        b = 0;
        while (done_cnt == d0 && b < 200) begin @(posedge clk); #1; b++; end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("no_err_in_burst", err_cnt - e0, 0);
        if (gap == 0) check("ready_cycles", ready_cnt, n);
    endtask

    task automatic bad_start(input int l);
        int e0;
        e0 = err_cnt;
        @(posedge clk); #1;
        start = 1'b1; len = LEN_W'(l);
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", {31'b0, err}, 1);
        check("err_busy_low", {31'b0, busy}, 0);
        @(posedge clk); #1;
        check("err_one_cycle", {31'b0, err}, 0);
        check("err_count", err_cnt - e0, 1);
        check("err_results_kept", {16'b0, max_val, max_idx, min_val, min_idx}, {16'b0, last_res});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        smp_arr_t    d;
        logic [15:0] res;
        int          lat, n, gap, d_before;
        logic [3:0]  first_v;

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // len=4: 3,9,1,9 -- tie on 9 keeps index 1
        d = '{default: 4'd0};
        d[0] = 4'd3; d[1] = 4'd9; d[2] = 4'd1; d[3] = 4'd9;
        model(4, d, res, lat);
        check("model_pin_res", {16'b0, res}, 32'h9112);
        check("model_pin_lat", lat, 11 - SKIP);
        run_burst(4, d, 0, 16'h9112, 11 - SKIP, 1'b0);

        // len=1: 7
        d = '{default: 4'd0};
        d[0] = 4'd7;
        run_burst(1, d, 0, 16'h7070, 2, 1'b0);

        // rejected requests
        bad_start(0);
        bad_start(17);

        // len=3 with stalls: 5,2,14
        d = '{default: 4'd0};
        d[0] = 4'd5; d[1] = 4'd2; d[2] = 4'd14;
        run_burst(3, d, 4, 16'hE221, 0, 1'b0);

        // reset during CMP_MAX of a len=8 burst
        first_v  = 4'($urandom_range(1, 15));
        d_before = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; len = LEN_W'(8); in_valid = 1'b1; in_data = first_v;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_data = 4'($urandom);
        @(posedge clk); #1;
        check("pre_reset_max_val", {28'b0, max_val}, {28'b0, first_v});
        check("pre_reset_busy", {31'b0, busy}, 1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst = 1'b0;
        exp_q.delete(); lat_q.delete(); last_res = '0;
        repeat (5) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt - d_before, 0);

        d = '{default: 4'd0};
        d[0] = 4'd0; d[1] = 4'd15;
        run_burst(2, d, 0, 16'hF100, 5 - SKIP, 1'b0);

        // start pulsed while busy: 4,4,8,1,8
        d = '{default: 4'd0};
        d[0] = 4'd4; d[1] = 4'd4; d[2] = 4'd8; d[3] = 4'd1; d[4] = 4'd8;
        run_burst(5, d, 0, 16'h8213, 14 - SKIP, 1'b1);

        // randomized bursts against the model
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, LEN_MAX);
            d = '{default: 4'd0};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) d[i] = 4'($urandom_range(6, 9));
                else                           d[i] = 4'($urandom_range(0, 15));
            end
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            model(n, d, res, lat);
            run_burst(n, d, gap, res, lat, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) bad_start(0);
                else                           bad_start($urandom_range(17, 31));
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
